pc_ctrl: RTL and testbench

- Program-counter stage of the single-cycle core. Sits directly downstream of the ALU.
- Consumes the ALU branch flag (f) and result (C), selects the next PC, and holds the PC register.
- Holds a one-entry pending-redirect buffer for redirects that arrive during fetch stalls.
- Runs a small boot/run/trap state machine, and traps on misaligned targets.

---
 rtl/pc_ctrl.sv | 112 +++++++++++
 tb/tb_pc_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter stage; next-PC select, pending redirect buffer, boot/run/trap FSM.
//   in : clk, rst (async, active-high), npc_op, ex_valid, imm, alu_c, alu_f, stall, trap_ack
//   out: pc, pc4, fetch_req, taken, trap, trap_pc
//   PC_CTRL_PERF_EN adds redirect_cnt and stall_cnt performance counters.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  npc_op,
  input  logic        ex_valid,
  input  logic [31:0] imm,
  input  logic [31:0] alu_c,
  input  logic        alu_f,
  input  logic        stall,
  input  logic        trap_ack,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fetch_req,
  output logic        taken,
  output logic        trap,
  output logic [31:0] trap_pc
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
  state_t state, state_n;
  logic [31:0] target, pc_n, pend_target, pend_target_n, trap_pc_n;
  logic pend_valid, pend_valid_n, taken_n, redirect;
  assign pc4 = pc + 32'd4;
  assign fetch_req = state == RUN;
  assign trap = state == TRAP;
  assign redirect = ex_valid & (npc_op[1] | (npc_op == 2'b01 & alu_f));
  assign target = npc_op == 2'b11 ? alu_c & ~32'h1
                : (npc_op == 2'b10 | (npc_op == 2'b01 & alu_f)) ? pc + imm : pc4;
  always_comb begin
    state_n = state;
    pc_n = pc;
    pend_valid_n = pend_valid;
    pend_target_n = pend_target;
    trap_pc_n = trap_pc;
    taken_n = 1'b0;
    case (state)
      BOOT: state_n = RUN;
      RUN:
        if (stall) begin
          // only the oldest redirect is kept; later ones during the stall are wrong-path
          if (redirect && !pend_valid) begin
            if (target[1]) begin
              state_n = TRAP;
              trap_pc_n = target;
              pend_valid_n = 1'b0;
            end else begin
              pend_valid_n = 1'b1;
              pend_target_n = target;
            end
          end
        end else if (pend_valid) begin
          // pend_target was alignment-checked when it was captured
          pc_n = pend_target;
          pend_valid_n = 1'b0;
          taken_n = 1'b1;
        end else if (ex_valid) begin
          if (target[1]) begin
            state_n = TRAP;
            trap_pc_n = target;
          end else begin
            pc_n = target;
            taken_n = redirect;
          end
        end
      TRAP:
        if (trap_ack) begin
          pc_n = TRAP_VEC;
          state_n = RUN;
        end
      default: state_n = BOOT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc <= RESET_PC;
      pend_valid <= 1'b0;
      pend_target <= 32'h0;
      trap_pc <= 32'h0;
      taken <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      pend_valid <= pend_valid_n;
      pend_target <= pend_target_n;
      trap_pc <= trap_pc_n;
      taken <= taken_n;
    end
  end
`ifdef PC_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      redirect_cnt <= redirect_cnt + {31'h0, taken};
      stall_cnt <= stall_cnt + {31'h0, state == RUN && stall};
    end
  end
`endif
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: scoreboard bench for pc_ctrl.
module tb_pc_ctrl;
  localparam logic [1:0] SEQ = 2'd0, BR = 2'd1, JAL = 2'd2, JALR = 2'd3;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] npc_op = SEQ;
  logic ex_valid = 1'b0, alu_f = 1'b0, stall = 1'b0, trap_ack = 1'b0;
  logic [31:0] imm = 32'h0, alu_c = 32'h0;
  logic [31:0] pc, pc4, trap_pc;
  logic fetch_req, taken, trap;
`ifdef PC_CTRL_PERF_EN
  logic [31:0] redirect_cnt, stall_cnt;
`endif
  typedef struct packed {
    logic [1:0] op;
    logic v;
    logic [31:0] im;
    logic [31:0] c;
    logic f;
    logic st;
    logic ack;
    logic [31:0] epc;
    logic tk;
    logic tr;
    logic fr;
  } row_t;
  row_t sb[$];
  int checks = 0, passes = 0;
  pc_ctrl dut (
    .clk(clk), .rst(rst), .npc_op(npc_op), .ex_valid(ex_valid), .imm(imm), .alu_c(alu_c),
    .alu_f(alu_f), .stall(stall), .trap_ack(trap_ack), .pc(pc), .pc4(pc4),
    .fetch_req(fetch_req), .taken(taken), .trap(trap), .trap_pc(trap_pc)
`ifdef PC_CTRL_PERF_EN
    , .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic apply(input row_t r);
    sb.push_back(r);
    npc_op = r.op;
    ex_valid = r.v;
    imm = r.im;
    alu_c = r.c;
    alu_f = r.f;
    stall = r.st;
    trap_ack = r.ack;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({pc, fetch_req, taken, trap, trap_pc} !== {32'h0, 1'b0, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset pc=%h fr=%b tk=%b tr=%b tpc=%h want all zero", pc, fetch_req, taken, trap, trap_pc);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (fetch_req !== 1'b0) $display("FAIL boot_fr got=%b want=0", fetch_req);
    else passes++;
  endtask
  task automatic test_seq();
    row_t r[3] = '{
      '{SEQ, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1},
      '{SEQ, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b1},
      '{SEQ, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8, 1'b0, 1'b0, 1'b1}};
    row_t e;
    for (int i = 0; i < 3; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      checks++;
      if ({pc, pc4, taken, trap, fetch_req} !== {e.epc, e.epc + 32'd4, e.tk, e.tr, e.fr})
        $display("FAIL seq[%0d] pc=%h pc4=%h tk=%b tr=%b fr=%b want pc=%h tk=%b tr=%b fr=%b",
                 i, pc, pc4, taken, trap, fetch_req, e.epc, e.tk, e.tr, e.fr);
      else passes++;
    end
  endtask
  task automatic test_branch();
    row_t r[5] = '{
      '{JAL, 1'b1, 32'h38, 32'h0, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 1'b1},
      '{BR, 1'b1, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h60, 1'b1, 1'b0, 1'b1},
      '{JAL, 1'b1, 32'hFFFF_FFE0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 1'b1},
      '{BR, 1'b1, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h44, 1'b0, 1'b0, 1'b1},
      '{JAL, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h44, 1'b0, 1'b0, 1'b1}};
    row_t e;
    for (int i = 0; i < 5; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      checks++;
      if ({pc, pc4, taken, trap, fetch_req} !== {e.epc, e.epc + 32'd4, e.tk, e.tr, e.fr})
        $display("FAIL branch[%0d] pc=%h pc4=%h tk=%b tr=%b fr=%b want pc=%h tk=%b tr=%b fr=%b",
                 i, pc, pc4, taken, trap, fetch_req, e.epc, e.tk, e.tr, e.fr);
      else passes++;
    end
  endtask
  task automatic test_jalr_trap();
    row_t r[4] = '{
      '{JALR, 1'b1, 32'h0, 32'h1001, 1'b0, 1'b0, 1'b0, 32'h1000, 1'b1, 1'b0, 1'b1},
      '{JALR, 1'b1, 32'h0, 32'h1007, 1'b0, 1'b0, 1'b0, 32'h1000, 1'b0, 1'b1, 1'b0},
      '{JAL, 1'b1, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1000, 1'b0, 1'b1, 1'b0},
      '{SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1}};
    row_t e;
    for (int i = 0; i < 4; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      checks++;
      if ({pc, pc4, taken, trap, fetch_req} !== {e.epc, e.epc + 32'd4, e.tk, e.tr, e.fr})
        $display("FAIL jalr_trap[%0d] pc=%h pc4=%h tk=%b tr=%b fr=%b want pc=%h tk=%b tr=%b fr=%b",
                 i, pc, pc4, taken, trap, fetch_req, e.epc, e.tk, e.tr, e.fr);
      else passes++;
    end
    checks++;
    if (trap_pc !== 32'h1006) $display("FAIL jalr_trap_pc got=%h want=00001006", trap_pc);
    else passes++;
  endtask
  task automatic test_stall_pend();
    row_t r[8] = '{
      '{JAL, 1'b1, 32'hFFFF_FF80, 32'h0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b1, 1'b0, 1'b1},
      '{JAL, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 1'b1},
      '{JALR, 1'b1, 32'h0, 32'h200, 1'b0, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 1'b1},
      '{JALR, 1'b1, 32'h0, 32'h300, 1'b0, 1'b0, 1'b0, 32'h90, 1'b1, 1'b0, 1'b1},
      '{SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h90, 1'b0, 1'b0, 1'b1},
      '{SEQ, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h94, 1'b0, 1'b0, 1'b1},
      '{BR, 1'b1, 32'h6, 32'h0, 1'b1, 1'b1, 1'b0, 32'h94, 1'b0, 1'b1, 1'b0},
      '{SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1}};
    row_t e;
    for (int i = 0; i < 8; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      checks++;
      if ({pc, pc4, taken, trap, fetch_req} !== {e.epc, e.epc + 32'd4, e.tk, e.tr, e.fr})
        $display("FAIL stall_pend[%0d] pc=%h pc4=%h tk=%b tr=%b fr=%b want pc=%h tk=%b tr=%b fr=%b",
                 i, pc, pc4, taken, trap, fetch_req, e.epc, e.tk, e.tr, e.fr);
      else passes++;
    end
    checks++;
    if (trap_pc !== 32'h9A) $display("FAIL stall_trap_pc got=%h want=0000009a", trap_pc);
    else passes++;
  endtask
  task automatic test_async_reset();
    row_t setup[2] = '{
      '{JAL, 1'b1, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1},
      '{JAL, 1'b1, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0}};
    row_t post[2] = '{
      '{SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1},
      '{SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}};
    row_t e;
    for (int k = 0; k < 2; k++) begin
      apply(setup[k]);
      e = sb.pop_front();
      checks++;
      if ({pc, taken, trap, fetch_req} !== {e.epc, e.tk, e.tr, e.fr})
        $display("FAIL areset_setup[%0d] pc=%h tk=%b tr=%b fr=%b want pc=%h tk=%b tr=%b fr=%b",
                 k, pc, taken, trap, fetch_req, e.epc, e.tk, e.tr, e.fr);
      else passes++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({pc, fetch_req, taken, trap, trap_pc} !== {32'h0, 1'b0, 1'b0, 1'b0, 32'h0})
        $display("FAIL areset_now[%0d] pc=%h fr=%b tk=%b tr=%b tpc=%h want all zero",
                 k, pc, fetch_req, taken, trap, trap_pc);
      else passes++;
      @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (fetch_req !== 1'b0) $display("FAIL areset_boot[%0d] fr=%b want=0", k, fetch_req);
      else passes++;
      for (int i = 0; i < 2; i++) begin
        apply(post[i]);
        e = sb.pop_front();
        checks++;
        if ({pc, taken, trap, fetch_req} !== {e.epc, e.tk, e.tr, e.fr})
          $display("FAIL areset_post[%0d.%0d] pc=%h tk=%b tr=%b fr=%b want pc=%h tk=%b tr=%b fr=%b",
                   k, i, pc, taken, trap, fetch_req, e.epc, e.tk, e.tr, e.fr);
        else passes++;
      end
    end
  endtask
`ifdef PC_CTRL_PERF_EN
  task automatic test_perf();
    row_t r[7] = '{
      '{SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1},
      '{SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1},
      '{SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1},
      '{SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1},
      '{JAL, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b1},
      '{JAL, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 1'b1},
      '{SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0, 1'b1}};
    row_t e;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({redirect_cnt, stall_cnt} !== 64'h0)
      $display("FAIL perf_reset rc=%0d sc=%0d want 0 0", redirect_cnt, stall_cnt);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      apply(r[i]);
      e = sb.pop_front();
      checks++;
      if ({pc, taken, trap, fetch_req} !== {e.epc, e.tk, e.tr, e.fr})
        $display("FAIL perf[%0d] pc=%h tk=%b tr=%b fr=%b want pc=%h tk=%b tr=%b fr=%b",
                 i, pc, taken, trap, fetch_req, e.epc, e.tk, e.tr, e.fr);
      else passes++;
    end
    checks++;
    if ({redirect_cnt, stall_cnt} !== {32'd2, 32'd3})
      $display("FAIL perf_cnt rc=%0d sc=%0d want rc=2 sc=3", redirect_cnt, stall_cnt);
    else passes++;
  endtask
`endif
  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_jalr_trap();
    test_stall_pend();
    test_async_reset();
`ifdef PC_CTRL_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
